aes_dec_arbiter: RTL
====================

# aes_dec_arbiter

Round-robin sequencer that shares one iterative AES decryption core (`decipherDE`, Nr+1 enabled cycles per block) between two requesters. It latches the granted ciphertext and a software-loaded key, and drives the core's mode enable for exactly Nr+1 consecutive cycles. It then presents the plaintext on a valid/ready response channel tagged with the requester ID. It sits between the bus-side request ports and the decipher core instance.

## Interface
- `Nk`, default 4: key length in 32-bit words; passed to the core.
- `Nr`, default 10: number of rounds; legal values 10/12/14; the round counter is 4 bits wide.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; also tied to the core's `reset`.
- `key_load` in 1: load `key_in` into the key register.
- `key_in` in 32*Nk: new cipher key.
- `req0_valid` in 1 / `req0_ready` out 1 / `req0_data` in 128: requester 0 ciphertext channel.
- `req1_valid` in 1 / `req1_ready` out 1 / `req1_data` in 128: requester 1 ciphertext channel.
- `resp_valid` out 1 / `resp_ready` in 1: response handshake.
- `resp_data` out 128: plaintext; driven directly from `core_out`.
- `resp_id` out 1: index of the requester that owns the response.
- `core_en` out 1: drives the core's Mode1; Mode2 and Mode3 are tied 0.
- `core_in` out 128: registered ciphertext to the core `in`.
- `core_key` out 32*Nk: registered key to the core `key`.
- `core_out` in 128: core `out`.
- `busy` out 1: high in RUN or HOLD.

## Operation
- States: IDLE, RUN, HOLD. Reset puts the block in IDLE.
- Reset values:
  - `core_en`, `resp_valid`, `busy`, `resp_id`: 0.
  - `core_in`, `core_key`: 0.
  - Round counter `rnd`: 0.
  - Last-served pointer `last`: 1, so requester 0 wins the first tie.
- IDLE, key load:
  - `key_load=1` writes `core_key<=key_in`.
  - Both ready outputs are forced 0 in that cycle; key load has priority over requests.
- IDLE, arbitration (when `key_load=0`):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant `!last`.
  - `reqX_ready` is combinational, high only for the granted X. It depends on the valid inputs; requesters must not make valid depend on ready.
- IDLE, accept edge (`reqX_valid && reqX_ready`):
  - `core_in<=reqX_data`, `resp_id<=X`, `last<=X`, `rnd<=0`, `core_en<=1`, go to RUN.
- RUN:
  - `core_en=1` every cycle; `rnd` increments on each edge.
  - On the edge where `rnd==Nr`: `core_en<=0`, `rnd<=0`, go to HOLD. This is Nr+1 enabled edges in total, matching the core's internal count 0..Nr.
- RUN restrictions:
  - `key_load` is ignored; `core_key` stays unchanged.
  - Both ready outputs are 0.
- HOLD:
  - `resp_valid=1`, `resp_data=core_out`; the core holds its output while `core_en=0`.
  - On `resp_ready=1`: go to IDLE. `resp_valid` stays high until then; no timeout.
  - `key_load` is ignored in HOLD.
- Boundaries:
  - A requester that drops valid before its grant is never served.
  - `core_en` is never deasserted mid-block except by reset.
- Reset mid-RUN or mid-HOLD: immediately returns to IDLE with all reset values. The in-flight block is discarded and no response is produced. The core resets together with the controller, so counters cannot desynchronise.

## Timing
- Accept at edge E0; `core_en` is high in the cycles ending at edges E1..E(Nr+1).
- `resp_valid` rises after E(Nr+1): Nr+1 cycles after accept (11 for Nr=10).
- Minimum block period is Nr+3 cycles (13 for Nr=10): 1 IDLE cycle, Nr+1 RUN cycles, 1 HOLD cycle with `resp_ready=1`.
- A key loaded in IDLE cycle c is usable by an accept no earlier than cycle c+1.
- Requests are never accepted in the same cycle as a response handshake; the next accept is the following IDLE cycle.

## Test plan
- Single request (FIPS-197 C.1 vector):
  - Stimulus: load key 000102030405060708090a0b0c0d0e0f, then `req0` ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: `resp_valid` exactly 11 cycles after accept, `resp_data`=00112233445566778899aabbccddeeff, `resp_id`=0, `core_en` high exactly 11 cycles.
- Contention:
  - Stimulus: `req0` and `req1` valid continuously with different blocks, `resp_ready=1`.
  - Response: grants alternate 0,1,0,1; accepts are 13 cycles apart; `resp_id` matches the order.
- Response backpressure:
  - Stimulus: hold `resp_ready=0` for 20 cycles in HOLD.
  - Response: `resp_valid` and `resp_data` stay stable; both ready outputs stay 0; `core_en` stays 0.
- Key collision:
  - Stimulus: assert `key_load` in RUN with key ff..ff.
  - Response: `core_key` unchanged and the result is still the correct plaintext. A subsequent `key_load` in IDLE, asserted with `req0_valid`, updates the key and blocks acceptance for that one cycle.
- Reset mid-operation:
  - Stimulus: assert `reset` at round 5.
  - Response: all outputs return to reset values at once; no response appears. After release, a fresh request decrypts correctly with latency 11.
- Valid withdrawn:
  - Stimulus: `req1_valid` pulses for a cycle while the block is in RUN.
  - Response: `req1` is never granted and no `resp_id`=1 response appears.

Source files
------------

// File: rtl/aes_dec_arbiter.sv
// -----------------------------------------------------------------------------
// aes_dec_arbiter
//
// Round-robin sequencer that shares one iterative AES decryption core between
// two requesters. A granted ciphertext and a software-loaded key are latched
// and presented to the core, whose mode enable is held high for exactly Nr+1
// consecutive cycles. The core's plaintext is then offered on a valid/ready
// response channel tagged with the owning requester's ID.
//
// Parameters
//   Nk          key length in 32-bit words (passed through to the core)
//   Nr          number of rounds (10/12/14); round counter is 4 bits wide
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset (shared with the core)
//   key_load    load key_in into the key register (IDLE only)
//   key_in      new cipher key
//   reqX_valid  requester X has a ciphertext block on reqX_data
//   reqX_ready  combinational grant for requester X (IDLE only)
//   reqX_data   requester X ciphertext
//   resp_valid  plaintext available on resp_data (HOLD state)
//   resp_ready  response consumer accepts the plaintext
//   resp_data   plaintext, taken directly from core_out
//   resp_id     requester that owns the response
//   core_en     core Mode1 enable
//   core_in     registered ciphertext to the core
//   core_key    registered key to the core
//   core_out    core plaintext output
//   busy        high while a block is in RUN or HOLD
// -----------------------------------------------------------------------------
module aes_dec_arbiter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [32*Nk-1:0]  key_in,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [127:0]      req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [127:0]      req1_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [127:0]      resp_data,
    output logic              resp_id,
    output logic              core_en,
    output logic [127:0]      core_in,
    output logic [32*Nk-1:0]  core_key,
    input  logic [127:0]      core_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] RND_LAST = 4'(Nr);

    state_t      state_r;
    logic [3:0]  rnd_r;
    logic        last_r;      // requester served most recently
    logic        grant_vld_s; // some requester is granted this cycle
    logic        grant_id_s;  // which requester is granted

    // Round-robin grant: only in IDLE, and key loading wins over requests.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        if ((state_r == ST_IDLE) && !key_load) begin
            if (req0_valid && req1_valid) begin
                grant_vld_s = 1'b1;
                grant_id_s  = ~last_r;
            end else if (req0_valid) begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b0;
            end else if (req1_valid) begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b1;
            end else begin
                grant_vld_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    // Ready outputs follow the grant directly.
    always_comb begin
        req0_ready = grant_vld_s & ~grant_id_s;
        req1_ready = grant_vld_s &  grant_id_s;
    end

    // The core holds its result while disabled, so the plaintext is passed through.
    always_comb begin
        resp_data = core_out;
    end

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rnd_r      <= 4'd0;
            last_r     <= 1'b1;
            core_en    <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            resp_id    <= 1'b0;
            core_in    <= 128'd0;
            core_key   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (key_load) begin
                        core_key <= key_in;
                    end else if (grant_vld_s) begin
                        core_in <= grant_id_s ? req1_data : req0_data;
                        resp_id <= grant_id_s;
                        last_r  <= grant_id_s;
                        rnd_r   <= 4'd0;
                        core_en <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Nr+1 enabled edges: rnd counts 0..Nr in step with the core.
                    if (rnd_r == RND_LAST) begin
                        core_en    <= 1'b0;
                        rnd_r      <= 4'd0;
                        resp_valid <= 1'b1;
                        state_r    <= ST_HOLD;
                    end else begin
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rnd_r      <= 4'd0;
                    core_en    <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
